// File: rtl/drenador_fifos_if.sv
`default_nettype none
// ============================================================================
// Module   : drenador_fifos_if
// Purpose  : Bundle of the blue-FIFO read side and the merged output stream
//            used by the drain stage. "master" is the drain's view, "slave"
//            is the view of the environment (FIFOs plus downstream sink).
// Revision : 1.0 - initial release
// ============================================================================
interface drenador_fifos_if #(
  parameter int DATA_WIDTH = 12
);
  // FIFO side
  logic                      Enable;
  logic [3:0]                fifo_empty;
  logic [4*DATA_WIDTH-1:0]   data_in;
  logic [3:0]                pop_fifo_azules;
  // Stream side
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     data_out;
  logic [1:0]                port_out;
  logic                      valid_out;
  // Status
  logic                      idle;

  modport master (
    input  Enable, fifo_empty, data_in, out_ready,
    output pop_fifo_azules, data_out, port_out, valid_out, idle
  );

  modport slave (
    output Enable, fifo_empty, data_in, out_ready,
    input  pop_fifo_azules, data_out, port_out, valid_out, idle
  );
endinterface
`default_nettype wire

// File: rtl/drenador_fifos.sv
`default_nettype none
// ============================================================================
// Module   : drenador_fifos
// Purpose  : Round-robin drain of four blue FIFOs into one valid/ready
//            stream tagged with the source index. A 2-entry output queue
//            and a credit check on pop issue guarantee no loss and no
//            over-pop under back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module drenador_fifos #(
  parameter int DATA_WIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active low
  drenador_fifos_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             count_q, count_d;
  logic                   pending_q, pending_d;
  logic [1:0]             pend_port_q, pend_port_d;
  logic [1:0]             last_q, last_d;
  logic                   idle_q, idle_d;
  // Queue slot 0 is the head, slot 1 the tail when two words are held.
  logic [1:0]             port0_q, port0_d, port1_q, port1_d;
  logic [DATA_WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;

  logic                   deq;
  logic                   credit_ok;
  logic [2:0]             occupancy;
  logic [3:0]             eligible;
  logic                   grant_valid;
  logic [1:0]             grant_idx;
  logic [1:0]             cand;
  logic                   pop_en;
  logic [DATA_WIDTH-1:0]  cap_data;

  // Eligibility, credit check and round-robin grant for this cycle's pop.
  always_comb begin
    deq       = (count_q != 2'd0) && bus.out_ready;
    occupancy = {1'b0, count_q} + {2'b00, pending_q};
    // Words already held or in flight, minus the one leaving now, must
    // leave room for the word this pop would bring in.
    credit_ok = occupancy < (3'd2 + {2'b00, deq});
    for (int i = 0; i < 4; i++) begin
      // A FIFO popped last cycle still shows its pre-pop empty flag.
      eligible[i] = !bus.fifo_empty[i] && !(pending_q && (pend_port_q == 2'(i)));
    end
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    pop_en = (state_q == ST_ACTIVE) && bus.Enable && credit_ok && grant_valid;
    bus.pop_fifo_azules = pop_en ? (4'b0001 << grant_idx) : 4'b0000;
  end

  // Select the read data of the FIFO popped last cycle.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (pend_port_q == 2'(i)) begin
        cap_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output queue: enqueue the captured word, dequeue on accept.
  always_comb begin
    count_d = count_q;
    port0_d = port0_q;
    port1_d = port1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    case (count_q)
      2'd0: begin
        if (pending_q) begin
          port0_d = pend_port_q;
          data0_d = cap_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (deq && pending_q) begin
          port0_d = pend_port_q;
          data0_d = cap_data;
        end else if (deq) begin
          count_d = 2'd0;
        end else if (pending_q) begin
          port1_d = pend_port_q;
          data1_d = cap_data;
          count_d = 2'd2;
        end
      end
      2'd2: begin
        if (deq) begin
          port0_d = port1_q;
          data0_d = data1_q;
          if (pending_q) begin
            port1_d = pend_port_q;
            data1_d = cap_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Next state of the drain controller and pop bookkeeping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Enable && (bus.fifo_empty != 4'hF)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!bus.Enable) begin
          state_d = ST_FLUSH;
        end else if ((bus.fifo_empty == 4'hF) && !pending_q && (count_q == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.Enable) begin
          state_d = ST_ACTIVE;
        end else if (!pending_q && (count_q == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d      = (state_d == ST_IDLE);
    pending_d   = pop_en;
    pend_port_d = pop_en ? grant_idx : pend_port_q;
    last_d      = pop_en ? grant_idx : last_q;
  end

  // State registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 2'd0;
      pending_q   <= 1'b0;
      pend_port_q <= 2'd0;
      last_q      <= 2'd3;
      idle_q      <= 1'b1;
      port0_q     <= 2'd0;
      port1_q     <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      pend_port_q <= pend_port_d;
      last_q      <= last_d;
      idle_q      <= idle_d;
      port0_q     <= port0_d;
      port1_q     <= port1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
    end
  end

  // Head of the queue drives the stream.
  always_comb begin
    bus.data_out  = data0_q;
    bus.port_out  = port0_q;
    bus.valid_out = (count_q != 2'd0);
    bus.idle      = idle_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_drenador_fifos.sv
`default_nettype none
// ============================================================================
// Module   : tb_drenador_fifos
// Purpose  : Self-checking bench for drenador_fifos: FIFO models with a
//            one-cycle-late empty flag, a queue-based reference model, and
//            directed plus random scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drenador_fifos;
  localparam int W = 12;

  typedef logic [W-1:0] wq_t[$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drenador_fifos_if #(.DATA_WIDTH(W)) bus ();
  drenador_fifos #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Environment FIFO contents
  wq_t fq[4];
  // Reference model
  int            m_state;      // 0 idle, 1 active, 2 flush
  logic [13:0]   mq[$];        // {port, data}
  bit            m_pend;
  logic [1:0]    m_pport;
  logic [W-1:0]  m_pword;
  logic [1:0]    m_last;
  bit            m_idle;
  // Values seen during the cycle being closed
  bit            s_e, s_r, s_valid;
  logic [3:0]    s_fe;
  int            s_idx;
  // Observation logs (from the DUT)
  int            pop_cyc[$];
  int            pop_idx[$];
  int            val_cyc[$];
  logic [13:0]   out_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); pop_idx.delete(); val_cyc.delete(); out_log.delete();
  endtask

  task automatic reset_models();
    for (int i = 0; i < 4; i++) fq[i].delete();
    mq.delete();
    m_state = 0; m_pend = 0; m_pport = 2'd0; m_pword = '0;
    m_last = 2'd3; m_idle = 1; s_idx = -1;
    bus.fifo_empty = 4'hF;
    bus.data_in    = '0;
  endtask

  function automatic bit all_empty();
    return (fq[0].size() == 0) && (fq[1].size() == 0) &&
           (fq[2].size() == 0) && (fq[3].size() == 0);
  endfunction

  // Which FIFO the rules say must be popped now (-1 for none).
  function automatic int model_pop();
    int idx = -1;
    int sz  = mq.size();
    int d   = (sz != 0 && bus.out_ready) ? 1 : 0;
    if (m_state == 1 && bus.Enable && (sz + int'(m_pend) - d < 2)) begin
      for (int k = 1; k <= 4; k++) begin
        int i = (int'(m_last) + k) % 4;
        if (idx < 0 && !bus.fifo_empty[i] && !(m_pend && int'(m_pport) == i)) idx = i;
      end
    end
    return idx;
  endfunction

  // Advance FIFOs and model across the clock edge just taken.
  task automatic edge_update();
    logic [3:0]     nfe;
    logic [W-1:0]   w = '0;
    logic [4*W-1:0] din;
    int             ns = m_state;
    for (int i = 0; i < 4; i++) nfe[i] = (fq[i].size() == 0);
    din = 48'({$urandom(), $urandom()});
    if (s_idx >= 0) begin
      chk("pop_of_nonempty_fifo", fq[s_idx].size() != 0, 1);
      if (fq[s_idx].size() != 0) begin
        w = fq[s_idx].pop_front();
        din[s_idx*W +: W] = w;
      end
    end
    bus.data_in    = din;
    bus.fifo_empty = nfe;
    case (m_state)
      0: if (s_e && s_fe != 4'hF) ns = 1;
      1: if (!s_e) ns = 2;
         else if (s_fe == 4'hF && !m_pend && mq.size() == 0) ns = 0;
      default: if (s_e) ns = 1;
               else if (!m_pend && mq.size() == 0) ns = 0;
    endcase
    if (s_valid && s_r) void'(mq.pop_front());
    if (m_pend) mq.push_back({m_pport, m_pword});
    m_pend = (s_idx >= 0);
    if (m_pend) begin
      m_pport = 2'(s_idx);
      m_pword = w;
      m_last  = 2'(s_idx);
    end
    m_state = ns;
    m_idle  = (ns == 0);
  endtask

  // One clock cycle: compare at the falling edge, then advance.
  task automatic step();
    int         e_idx;
    logic [3:0] e_pop;
    @(negedge clk);
    e_idx = model_pop();
    e_pop = (e_idx >= 0) ? (4'b0001 << e_idx) : 4'b0000;
    chk("pop", bus.pop_fifo_azules, e_pop);
    chk("valid_out", bus.valid_out, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("data_out", bus.data_out, mq[0][W-1:0]);
      chk("port_out", bus.port_out, mq[0][13:12]);
    end
    chk("idle", bus.idle, m_idle);
    if (bus.pop_fifo_azules != 4'b0000) begin
      pop_cyc.push_back(cyc);
      for (int i = 0; i < 4; i++) if (bus.pop_fifo_azules[i]) pop_idx.push_back(i);
    end
    if (bus.valid_out) val_cyc.push_back(cyc);
    if (bus.valid_out && bus.out_ready) out_log.push_back({bus.port_out, bus.data_out});
    s_e = bus.Enable; s_r = bus.out_ready; s_fe = bus.fifo_empty;
    s_idx = e_idx; s_valid = (mq.size() != 0);
    @(posedge clk);
    #1;
    edge_update();
    cyc++;
  endtask

  task automatic run_until_idle(input int maxc, input bit need_empty, input string nm);
    bit done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      step();
      if (bus.idle && (!need_empty || all_empty())) done = 1;
    end
    chk(nm, done, 1);
  endtask

  logic [13:0] rr_exp[4];
  logic [13:0] bp_exp[4];
  int          pushed;
  bit          found;

  initial begin
    rr_exp = '{14'h000A, 14'h110B, 14'h220C, 14'h330D};
    bp_exp = '{14'h0111, 14'h1333, 14'h0222, 14'h1444};
    reset = 1'b0;
    bus.Enable = 1'b0;
    bus.out_ready = 1'b0;
    reset_models();
    #12;
    // Reset values
    chk("rst_pop", bus.pop_fifo_azules, 4'h0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 12'h000);
    chk("rst_port", bus.port_out, 2'd0);
    chk("rst_idle", bus.idle, 1);
    @(posedge clk); #1; reset = 1'b1;
    bus.Enable = 1'b1;
    repeat (4) step();
    chk("empty_stays_idle", bus.idle, 1);
    chk("empty_no_pops", pop_idx.size(), 0);

    // Round robin, one word per FIFO
    clear_logs();
    fq[0].push_back(12'h00A); fq[1].push_back(12'h10B);
    fq[2].push_back(12'h20C); fq[3].push_back(12'h30D);
    bus.out_ready = 1'b1;
    repeat (4) step();
    run_until_idle(40, 1, "rr_return_idle");
    chk("rr_npops", pop_idx.size(), 4);
    for (int k = 0; k < 4 && k < pop_idx.size(); k++) begin
      chk("rr_pop_order", pop_idx[k], k);
      chk("rr_pop_consecutive", pop_cyc[k] - pop_cyc[0], k);
    end
    chk("rr_nwords", out_log.size(), 4);
    for (int k = 0; k < 4 && k < out_log.size(); k++) chk("rr_word", out_log[k], rr_exp[k]);
    if (val_cyc.size() > 0 && pop_cyc.size() > 0)
      chk("rr_latency", val_cyc[0] - pop_cyc[0], 2);
    else chk("rr_latency_seen", 0, 1);

    // Single non-empty FIFO: alternate-cycle pops
    clear_logs();
    fq[2].push_back(12'h2A1); fq[2].push_back(12'h2A2); fq[2].push_back(12'h2A3);
    repeat (4) step();
    run_until_idle(40, 1, "single_return_idle");
    chk("single_npops", pop_idx.size(), 3);
    for (int k = 0; k < pop_idx.size(); k++) chk("single_pop_idx", pop_idx[k], 2);
    for (int k = 1; k < pop_cyc.size(); k++) chk("single_pop_gap", pop_cyc[k] - pop_cyc[k-1], 2);
    chk("single_nwords", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("single_w0", out_log[0], 14'h22A1);
      chk("single_w1", out_log[1], 14'h22A2);
      chk("single_w2", out_log[2], 14'h22A3);
    end

    // Back-pressure: two pops fill the queue, head held
    clear_logs();
    bus.out_ready = 1'b0;
    fq[0].push_back(12'h111); fq[0].push_back(12'h222);
    fq[1].push_back(12'h333); fq[1].push_back(12'h444);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k >= 5) begin
        chk("bp_hold_valid", bus.valid_out, 1);
        chk("bp_hold_data", bus.data_out, 12'h111);
        chk("bp_hold_port", bus.port_out, 2'd0);
      end
    end
    chk("bp_npops", pop_idx.size(), 2);
    bus.out_ready = 1'b1;
    run_until_idle(40, 1, "bp_return_idle");
    chk("bp_nwords", out_log.size(), 4);
    for (int k = 0; k < 4 && k < out_log.size(); k++) chk("bp_word", out_log[k], bp_exp[k]);

    // Flush: Enable drops the cycle after a pop
    clear_logs();
    fq[3].push_back(12'h3A1); fq[3].push_back(12'h3A2); fq[3].push_back(12'h3A3);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (pop_idx.size() > 0) found = 1;
    end
    chk("flush_first_pop", found, 1);
    bus.Enable = 1'b0;
    run_until_idle(30, 0, "flush_return_idle");
    repeat (3) step();
    chk("flush_npops", pop_idx.size(), 1);
    chk("flush_nwords", out_log.size(), 1);
    if (out_log.size() > 0) chk("flush_word", out_log[0], 14'h33A1);
    chk("flush_idle", bus.idle, 1);

    // Mid-operation reset with count = 1 and a pop in flight
    clear_logs();
    fq[0].push_back(12'h0C1); fq[1].push_back(12'h1C1);
    bus.Enable = 1'b1;
    bus.out_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (mq.size() == 1 && m_pend) found = 1;
    end
    chk("mr_reach_state", found, 1);
    chk("mr_valid_before", bus.valid_out, 1);
    #2; reset = 1'b0; #1;
    chk("mr_valid_now", bus.valid_out, 0);
    chk("mr_pop_now", bus.pop_fifo_azules, 4'h0);
    chk("mr_idle_now", bus.idle, 1);
    reset_models();
    @(posedge clk); #1; reset = 1'b1;
    bus.out_ready = 1'b1;
    clear_logs();
    repeat (5) step();
    chk("mr_no_stale_valid", val_cyc.size(), 0);
    chk("mr_no_pops", pop_idx.size(), 0);

    // Random traffic against the model
    clear_logs();
    pushed = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2, 0) == 0) begin
        int f = int'($urandom_range(3, 0));
        if (fq[f].size() < 6) begin
          fq[f].push_back(12'($urandom()));
          pushed++;
        end
      end
      bus.Enable    = ($urandom_range(19, 0) != 0);
      bus.out_ready = ($urandom_range(2, 0) != 0);
      step();
    end
    bus.Enable = 1'b1;
    bus.out_ready = 1'b1;
    step();
    run_until_idle(300, 1, "rand_drain_idle");
    chk("rand_all_delivered", out_log.size(), pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
